// File: rtl/tgen_pkg.sv
// Shared types for the request traffic generator: FSM states, data pattern
// encoding and the write/expected data pattern helper.
package tgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  typedef enum logic {
    PAT_INDEX = 1'b0,
    PAT_INV   = 1'b1
  } pat_e;

  // Pattern is built 32 bits wide and truncated by the caller, so data widths up to 32 work.
  localparam int unsigned PAT_W = 32;

  function automatic logic [PAT_W-1:0] pat_word(input pat_e sel, input logic [PAT_W-1:0] idx);
    return (sel == PAT_INV) ? ~idx : idx;
  endfunction

  function automatic logic is_active(input state_e s);
    return (s == ST_WRITE) || (s == ST_READ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/tgen_checker.sv
// Read-return checker: expected data for the k-th in-order read return,
// compare, saturating error counter and first-error index capture.
module tgen_checker
  import tgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CW         = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [CW-1:0]         num,
  input  pat_e                  pat,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_all_c,
  output logic                  mismatch_c,
  output logic [CW-1:0]         error_count,
  output logic [CW-1:0]         first_err_index
);

  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         err_q, err_d;
  logic [CW-1:0]         ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] exp_c;
  logic                  take_c;

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    exp_c      = DATA_WIDTH'(pat_word(pat, PAT_W'(rd_cnt_q)));
    take_c     = enable && read_done && (rd_cnt_q < num);
    mismatch_c = take_c && (data_out != exp_c);
    if (clear) begin
      rd_cnt_d = '0;
      err_d    = '0;
      ferr_d   = '1;
    end else if (take_c) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
      if (mismatch_c) begin
        if (err_q != '1) err_d = err_q + CW'(1);
        if (err_q == '0) ferr_d = rd_cnt_q;
      end
    end
    rd_all_c = (rd_cnt_d == num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      err_q    <= '0;
      ferr_q   <= '1;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
      ferr_q   <= ferr_d;
    end
  end

  assign error_count     = err_q;
  assign first_err_index = ferr_q;

endmodule

// File: rtl/req_traffic_gen.sv
// Memory-controller traffic generator: writes a pattern over num_req addresses,
// reads them back in order, and reports pass/fail, error stats and run length.
module req_traffic_gen
  import tgen_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 16,
  parameter  int unsigned ADDR_WIDTH   = 30,
  parameter  int unsigned MAX_REQ      = 1024,
  parameter  int unsigned IDLE_TIMEOUT = 200,
  localparam int unsigned CW           = $clog2(MAX_REQ) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CW-1:0]         num_req,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  pattern_sel,
  input  logic                  out_busy,
  output logic                  in_valid,
  output logic                  in_request_type,
  output logic [ADDR_WIDTH-1:0] in_request_address,
  output logic [DATA_WIDTH-1:0] in_request_data,
  input  logic                  write_done,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         error_count,
  output logic [CW-1:0]         first_err_index,
  output logic [31:0]           cycle_count
);

  localparam int unsigned   TW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_REQ);
  localparam logic [TW-1:0] TMO   = TW'(IDLE_TIMEOUT);

  state_e                state_q, state_d;
  logic [CW-1:0]         num_q, num_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  pat_e                  pat_q, pat_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         sent_q, sent_d;
  logic [CW-1:0]         wdone_q, wdone_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic                  valid_q, valid_d;
  logic                  type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [31:0]           cyc_q, cyc_d;

  logic                  start_ok_c, xfer_c, can_load_c, chk_en_c;
  logic                  rd_all_c, mismatch_c;
  logic [CW-1:0]         num_clamp_c;

  tgen_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CW         (CW)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (start_ok_c),
    .enable          (chk_en_c),
    .num             (num_q),
    .pat             (pat_q),
    .read_done       (read_done),
    .data_out        (data_out),
    .rd_all_c        (rd_all_c),
    .mismatch_c      (mismatch_c),
    .error_count     (error_count),
    .first_err_index (first_err_index)
  );

  // Next-state and request-side datapath.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    base_d      = base_q;
    pat_d       = pat_q;
    idx_d       = idx_q;
    sent_d      = sent_q;
    wdone_d     = wdone_q;
    idle_d      = idle_q;
    valid_d     = valid_q;
    type_d      = type_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = done_q;
    pass_d      = pass_q;
    cyc_d       = cyc_q;
    start_ok_c  = start && !is_active(state_q);
    xfer_c      = valid_q && !out_busy;
    can_load_c  = !valid_q || xfer_c;
    chk_en_c    = (state_q == ST_READ) || (state_q == ST_DRAIN);
    num_clamp_c = (num_req > MAX_N) ? MAX_N : num_req;

    if (is_active(state_q)) cyc_d = cyc_q + 32'd1;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start_ok_c) begin
          state_d = ST_WRITE;
          num_d   = num_clamp_c;
          base_d  = base_addr;
          pat_d   = pat_e'(pattern_sel);
          idx_d   = '0;
          sent_d  = '0;
          wdone_d = '0;
          idle_d  = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cyc_d   = '0;
        end
      end

      ST_WRITE: begin
        if (xfer_c) sent_d = sent_q + CW'(1);
        if (write_done && (wdone_q < num_q)) wdone_d = wdone_q + CW'(1);
        if (num_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          if (can_load_c) begin
            if (idx_q < num_q) begin
              valid_d = 1'b1;
              type_d  = 1'b1;
              addr_d  = base_q + ADDR_WIDTH'(idx_q);
              data_d  = DATA_WIDTH'(pat_word(pat_q, PAT_W'(idx_q)));
              idx_d   = idx_q + CW'(1);
            end else begin
              valid_d = 1'b0;
            end
          end
          // Reads wait for every write to be acknowledged.
          if ((sent_d == num_q) && (wdone_d == num_q)) begin
            state_d = ST_READ;
            idx_d   = '0;
            sent_d  = '0;
            valid_d = 1'b0;
          end
        end
      end

      ST_READ: begin
        if (xfer_c) sent_d = sent_q + CW'(1);
        if (can_load_c) begin
          if (idx_q < num_q) begin
            valid_d = 1'b1;
            type_d  = 1'b0;
            addr_d  = base_q + ADDR_WIDTH'(idx_q);
            data_d  = '0;
            idx_d   = idx_q + CW'(1);
          end else begin
            valid_d = 1'b0;
          end
        end
        if (sent_d == num_q) begin
          state_d = ST_DRAIN;
          idle_d  = '0;
          valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        idle_d = read_done ? '0 : idle_q + TW'(1);
        if (rd_all_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (error_count == '0) && !mismatch_c;
        end else if (idle_d == TMO) begin
          state_d = ST_TIMEOUT;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      base_q  <= '0;
      pat_q   <= PAT_INDEX;
      idx_q   <= '0;
      sent_q  <= '0;
      wdone_q <= '0;
      idle_q  <= '0;
      valid_q <= 1'b0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      base_q  <= base_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      wdone_q <= wdone_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cyc_q   <= cyc_d;
    end
  end

  assign in_valid           = valid_q;
  assign in_request_type    = type_q;
  assign in_request_address = addr_q;
  assign in_request_data    = data_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign cycle_count        = cyc_q;

endmodule

// File: tb/tb_req_traffic_gen.sv
// Bench for req_traffic_gen: memory responder with configurable latency, stalls,
// corruption and withheld returns; run results checked against a queue-based model.
module tb_req_traffic_gen;

  localparam int DW   = 16;
  localparam int AW   = 30;
  localparam int CW   = 11;
  localparam int MAXR = 1024;
  localparam int TMO  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_req = '0;
  logic [AW-1:0] base_addr = '0;
  logic          pattern_sel = 1'b0;
  logic          out_busy = 1'b0;
  logic          in_valid, in_request_type;
  logic [AW-1:0] in_request_address;
  logic [DW-1:0] in_request_data;
  logic          write_done = 1'b0;
  logic          read_done = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          done, pass;
  logic [CW-1:0] error_count, first_err_index;
  logic [31:0]   cycle_count;

  req_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_req(num_req), .base_addr(base_addr),
    .pattern_sel(pattern_sel), .out_busy(out_busy), .in_valid(in_valid),
    .in_request_type(in_request_type), .in_request_address(in_request_address),
    .in_request_data(in_request_data), .write_done(write_done), .read_done(read_done),
    .data_out(data_out), .done(done), .pass(pass), .error_count(error_count),
    .first_err_index(first_err_index), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Knobs written only by the stimulus block.
  int k_lat = 1, k_stall_idx = -1, k_stall_len = 0, k_corrupt = -1, k_neff = 0;
  int k_spur = 0, epoch = 0;
  bit k_withhold = 0, k_rbusy = 0;

  // Responder / model state written only by the responder.
  int            cyc_n = 0;
  int            busy_left = 0, spur_cnt = 0, seen_epoch = 0;
  bit            stall_done = 0, hold_pend = 0;
  logic [47:0]   hold_snap = '0;
  logic [AW-1:0] wr_addr[$], rd_addr[$];
  logic [DW-1:0] wr_data[$], rd_ret[$], rd_dat[$];
  int            wr_edge[$], rd_edge[$], wd_due[$], rd_due[$];
  int            last_rd_edge = 0, last_wd_edge = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] pat(input bit p, input int k);
    logic [31:0] v;
    v = 32'(k);
    return p ? DW'(~v) : DW'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: everything is decided on the falling edge and labelled with the
  // number of the rising edge that will sample it.
  always @(negedge clk) begin : resp
    int idx;
    logic [DW-1:0] d;
    cyc_n++;
    write_done = 1'b0;
    read_done  = 1'b0;
    data_out   = '0;
    if (!rst_n || seen_epoch != epoch) begin
      seen_epoch = epoch;
      wr_addr.delete(); rd_addr.delete(); wr_data.delete(); rd_ret.delete(); rd_dat.delete();
      wr_edge.delete(); rd_edge.delete(); wd_due.delete(); rd_due.delete();
      busy_left = 0; stall_done = 0; hold_pend = 0; out_busy = 1'b0;
      last_rd_edge = 0; last_wd_edge = 0;
    end else begin
      if (hold_pend)
        check("hold_stable", 64'({in_valid, in_request_type, in_request_address, in_request_data}),
              64'(hold_snap));
      if (busy_left > 0) begin
        out_busy = 1'b1; busy_left--;
      end else if (in_valid && in_request_type && !stall_done && k_stall_len > 0 &&
                   wr_addr.size() == k_stall_idx) begin
        out_busy = 1'b1; busy_left = k_stall_len - 1; stall_done = 1;
      end else begin
        out_busy = k_rbusy ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      hold_pend = in_valid && out_busy;
      hold_snap = {in_valid, in_request_type, in_request_address, in_request_data};
      if (wd_due.size() > 0 && wd_due[0] == cyc_n) begin
        void'(wd_due.pop_front()); write_done = 1'b1; last_wd_edge = cyc_n;
      end
      if (rd_due.size() > 0 && rd_due[0] == cyc_n) begin
        void'(rd_due.pop_front()); read_done = 1'b1; data_out = rd_dat.pop_front();
        rd_ret.push_back(data_out); last_rd_edge = cyc_n;
      end
      if (spur_cnt < k_spur) begin
        spur_cnt++; write_done = 1'b1; read_done = 1'b1; data_out = 16'hBEEF;
      end
      if (in_valid && !out_busy) begin
        if (in_request_type) begin
          wr_addr.push_back(in_request_address); wr_data.push_back(in_request_data);
          wr_edge.push_back(cyc_n); mem[in_request_address] = in_request_data;
          wd_due.push_back(cyc_n + k_lat);
        end else begin
          idx = rd_addr.size();
          rd_addr.push_back(in_request_address); rd_edge.push_back(cyc_n);
          d = mem.exists(in_request_address) ? mem[in_request_address] : '0;
          if (idx == k_corrupt) d = d ^ 16'h0100;
          if (!(k_withhold && idx == k_neff - 1)) begin
            rd_due.push_back(cyc_n + k_lat); rd_dat.push_back(d);
          end
        end
      end
    end
  end

  task automatic run(input string tag, input int n, input logic [AW-1:0] base, input bit p,
                     input int lat, input int st_idx, input int st_len, input int corrupt,
                     input bit withhold, input bit rbusy, input bit mid_start);
    int neff, start_edge, done_edge, errs, ferr, bad, budget, tmo_ref;
    bit seen;
    logic [31:0] cc;
    neff = (n > MAXR) ? MAXR : n;
    k_lat = lat; k_stall_idx = st_idx; k_stall_len = st_len; k_corrupt = corrupt;
    k_withhold = withhold; k_rbusy = rbusy; k_neff = neff;
    epoch++;
    @(negedge clk); #1;
    num_req = CW'(n); base_addr = base; pattern_sel = p; start = 1'b1; start_edge = cyc_n;
    seen = 0; budget = neff * 16 + 600;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      start = mid_start && (i == 2);
      num_req = CW'($urandom_range(0, 2047)); base_addr = AW'($urandom); pattern_sel = ~p;
      if (done === 1'b1) begin seen = 1; break; end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    done_edge = cyc_n - 1;
    errs = 0; ferr = -1;
    foreach (rd_ret[k]) if (rd_ret[k] !== pat(p, k)) begin errs++; if (ferr < 0) ferr = k; end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_pass"}, 64'(pass), 64'(!withhold && errs == 0));
    check({tag, "_err_cnt"}, 64'(error_count), 64'(errs));
    check({tag, "_first_err"}, 64'(first_err_index), (ferr < 0) ? 64'h7FF : 64'(ferr));
    check({tag, "_cycles"}, 64'(cycle_count), 64'(done_edge - start_edge));
    if (n == 0) check({tag, "_zero_latency"}, 64'(done_edge - start_edge), 64'd1);
    check({tag, "_n_writes"}, 64'(wr_addr.size()), 64'(neff));
    check({tag, "_n_reads"}, 64'(rd_addr.size()), 64'(neff));
    bad = 0;
    for (int k = 0; k < neff && k < wr_addr.size(); k++)
      if (wr_addr[k] !== AW'(base + AW'(k)) || wr_data[k] !== pat(p, k)) bad++;
    for (int k = 0; k < neff && k < rd_addr.size(); k++)
      if (rd_addr[k] !== AW'(base + AW'(k))) bad++;
    check({tag, "_req_content"}, 64'(bad), 64'd0);
    if (neff > 0 && rd_edge.size() > 0)
      check({tag, "_read_after_wdone"}, 64'(rd_edge[0] > last_wd_edge), 64'd1);
    if (!rbusy && st_len == 0 && neff > 1) begin
      bad = 0;
      foreach (wr_edge[k]) if (wr_edge[k] != wr_edge[0] + k) bad++;
      foreach (rd_edge[k]) if (rd_edge[k] != rd_edge[0] + k) bad++;
      check({tag, "_back_to_back"}, 64'(bad), 64'd0);
    end
    if (withhold && rd_edge.size() > 0) begin
      tmo_ref = (last_rd_edge > rd_edge[rd_edge.size()-1]) ? last_rd_edge : rd_edge[rd_edge.size()-1];
      check({tag, "_timeout_edge"}, 64'(done_edge), 64'(tmo_ref + TMO));
    end
    cc = cycle_count;
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_hold"}, 64'({cycle_count, done, in_valid}), 64'({cc, 1'b1, 1'b0}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(in_valid), 64'd0);
    check({tag, "_type"}, 64'(in_request_type), 64'd0);
    check({tag, "_addr"}, 64'(in_request_address), 64'd0);
    check({tag, "_data"}, 64'(in_request_data), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_err"}, 64'(error_count), 64'd0);
    check({tag, "_ferr"}, 64'(first_err_index), 64'h7FF);
    check({tag, "_cyc"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    int n, bad, wait_cnt;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("basic", 4, 30'd2, 1'b0, 2, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    run("stall", 4, 30'd2, 1'b0, 2, 1, 3, -1, 1'b0, 1'b0, 1'b0);
    run("corrupt", 4, 30'd2, 1'b0, 2, -1, 0, 2, 1'b0, 1'b0, 1'b0);

    // Completion pulses while DONE must leave the results untouched.
    k_spur = k_spur + 3;
    repeat (6) @(negedge clk);
    #1;
    check("spurious_err", 64'({error_count, first_err_index, done, pass}), 64'({11'd1, 11'd2, 1'b1, 1'b0}));

    run("timeout", 4, 30'd2, 1'b0, 3, -1, 0, -1, 1'b1, 1'b0, 1'b0);
    run("zero", 0, 30'd2, 1'b0, 1, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    run("wrap", 2, 30'h3FFF_FFFF, 1'b0, 1, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    check("wrap_addr1", 64'(wr_addr.size() > 1 ? wr_addr[1] : 30'h1234), 64'd0);
    run("inv_pat", 5, 30'h100, 1'b1, 1, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    run("clamp", 1100, 30'h2000, 1'b1, 1, -1, 0, -1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      run($sformatf("rand%0d", r), n, AW'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(1, 4), -1, 0,
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1,
          1'b0, 1'b1, 1'b1);
    end

    // Reset in the middle of the read phase.
    k_lat = 2; k_stall_len = 0; k_corrupt = -1; k_withhold = 0; k_rbusy = 0; k_neff = 8;
    epoch++;
    @(negedge clk); #1;
    num_req = CW'(8); base_addr = 30'd100; pattern_sel = 1'b0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_cnt = 0;
    while (rd_addr.size() < 2 && wait_cnt < 300) begin @(negedge clk); #1; wait_cnt++; end
    check("rst_reached_read", 64'(rd_addr.size() >= 2), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); #1; if (in_valid !== 1'b0 || done !== 1'b0) bad++; end
    check("rst_quiet", 64'(bad), 64'd0);
    run("post_rst", 6, 30'd7, 1'b1, 2, -1, 0, -1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_traffic_gen.md
REQ_TRAFFIC_GEN -- requirements
Module: req_traffic_gen

Interface
REQ-001 Parameter DATA_WIDTH, 16, request/response data width.
REQ-002 Parameter ADDR_WIDTH, 30, request address width.
REQ-003 Parameter MAX_REQ, 1024, maximum requests per run; CW = $clog2(MAX_REQ)+1.
REQ-004 Parameter IDLE_TIMEOUT, 200, cycles without read_done in DRAIN before timeout.
REQ-005 clk input 1: single clock, all logic on posedge.
REQ-006 rst_n input 1: asynchronous, active-low reset.
REQ-007 start input 1: one-cycle pulse; begins a run from IDLE or from DONE/TIMEOUT.
REQ-008 num_req input CW: number of writes, and of reads, per run; sampled on start.
REQ-009 base_addr input ADDR_WIDTH: first address; sampled on start.
REQ-010 pattern_sel input 1: 0 = data is index, 1 = data is ~index; sampled on start.
REQ-011 out_busy input 1: controller cannot accept a request this cycle.
REQ-012 in_valid output 1: request present.
REQ-013 in_request_type output 1: 1 = write, 0 = read.
REQ-014 in_request_address output ADDR_WIDTH: base_addr + index, modulo 2^ADDR_WIDTH.
REQ-015 in_request_data output DATA_WIDTH: write pattern; 0 for reads.
REQ-016 write_done input 1 and read_done input 1: per-request completion pulses.
REQ-017 data_out input DATA_WIDTH: read data, valid when read_done=1.
REQ-018 done output 1, pass output 1, error_count output CW, first_err_index output CW, cycle_count output 32: run status.

Function
REQ-019 States IDLE, WRITE, READ, DRAIN, DONE, TIMEOUT; start takes any non-active state to WRITE, and is ignored in WRITE/READ/DRAIN.
REQ-020 A request transfers on a rising edge where in_valid=1 and out_busy=0; while out_busy=1 all request outputs are held stable.
REQ-021 Requests are issued back-to-back: one per cycle when out_busy stays low, no bubble after a transfer.
REQ-022 WRITE issues indices 0..num_req-1 with type 1 and data = index (pattern_sel=0) or ~index (pattern_sel=1), truncated to DATA_WIDTH.
REQ-023 WRITE -> READ after the last write transfers and write_done has been counted num_req times; in_valid=0 while waiting.
REQ-024 READ issues indices 0..num_req-1 with type 0; READ -> DRAIN after the last read transfers.
REQ-025 Read returns are in order: the k-th read_done is compared against the pattern of index k, in READ or DRAIN.
REQ-026 A mismatch increments error_count (saturating at all ones); the first mismatch loads first_err_index, which otherwise stays all ones.
REQ-027 DRAIN -> DONE when num_req read_done pulses have been counted; done=1, pass=(error_count==0).
REQ-028 The idle counter clears on any read_done and on DRAIN entry; when it reaches IDLE_TIMEOUT in DRAIN, go to TIMEOUT; done=1, pass=0.
REQ-029 num_req=0: go from WRITE directly to DONE in one cycle with pass=1 and no request issued.
REQ-030 num_req>MAX_REQ is clamped to MAX_REQ.
REQ-031 write_done or read_done arriving outside a run is ignored and is not counted.
REQ-032 A read_done that coincides with a read transfer is handled in the same cycle; both counters update.
REQ-033 cycle_count clears on start, increments every cycle in WRITE/READ/DRAIN, and holds in DONE/TIMEOUT.
REQ-034 start clears error_count, done, pass, first_err_index and all counters.

Reset
REQ-035 On rst_n low, the block enters IDLE at once.
REQ-036 Reset values: in_valid=0, type=0, address=0, data=0, done=0, pass=0, error_count=0, first_err_index=all ones, cycle_count=0.
REQ-037 Reset mid-run abandons the run; no request is issued until the next start after reset is released.

Structure
REQ-038 Shared package tgen_pkg holds the state enum and pattern_sel encoding.
REQ-039 Sub-module tgen_checker holds the expected-data generation, compare, error counter and first-error capture; the request-side FSM stays in req_traffic_gen.
REQ-040 The block is synthesizable, with no delays or tasks, so it can run in the emulation partition next to memory_controller.

Verification
REQ-041 num_req=4, base=2, pattern 0, out_busy=0, ideal responder: writes at addresses 2..5 with data 0..3, then reads; done=1, pass=1, error_count=0.
REQ-042 out_busy high for 3 cycles during write 1: outputs held, no duplicate or lost request; exactly 4 writes transfer.
REQ-043 Responder corrupts read index 2: error_count=1, first_err_index=2, pass=0.
REQ-044 Responder withholds the last read_done: TIMEOUT exactly 200 cycles after the previous read_done, done=1, pass=0.
REQ-045 num_req=0 gives done=1, pass=1 after one cycle; base=2^30-1 with num_req=2 gives addresses 3FFFFFFF, then 0.
REQ-046 rst_n low for 1 cycle mid-READ: all outputs at reset values at once; a new start then completes with pass=1.
